tcdm_lrsc_filter: RTL
=====================

TCDM_LRSC_FILTER -- requirements
Module: tcdm_lrsc_filter

Interface
REQ-001 SHALL have parameter AddrMemWidth, default 32, word address width.
REQ-002 SHALL have parameter DataWidth, default 64, data width; only 32 and 64 are legal.
REQ-003 SHALL have parameter NumCores, default 8, number of reservation slots (one per requester ID).
REQ-004 SHALL have parameter ResvTimeout, default 1024, reservation lifetime in cycles (used only under REQ-031).
REQ-005 SHALL have ports clk_i in 1 clock; rst_ni in 1 reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have master ports: in_req_i in 1; in_gnt_o out 1; in_add_i in AddrMemWidth; in_amo_i in 4; in_wen_i in 1; in_wdata_i in DataWidth; in_be_i in DataWidth/8; in_id_i in $clog2(NumCores); in_rdata_o out DataWidth.
REQ-007 SHALL have ports toward the downstream AMO stage: out_req_o out 1; out_gnt_i in 1; out_add_o out AddrMemWidth; out_amo_o out 4; out_wen_o out 1; out_wdata_o out DataWidth; out_be_o out DataWidth/8; out_rdata_i in DataWidth.

Function
REQ-008 SHALL pass every request with in_amo_i not LR (4'hB) and not SC (4'hC) through unchanged; out_req_o=in_req_i and in_gnt_o=out_gnt_i always.
REQ-009 SHALL define a handshake as in_req_i && out_gnt_i; all reservation state changes only on a handshake.
REQ-010 SHALL forward LR as a load: out_amo_o=AMONone, out_wen_o=0.
REQ-011 SHALL, on an LR handshake, set slot[in_id_i] valid with address in_add_i, overwriting any prior reservation of that ID.
REQ-012 SHALL evaluate SC as success iff slot[in_id_i] is valid and its address equals in_add_i.
REQ-013 SHALL forward a successful SC as a store: out_amo_o=AMONone, out_wen_o=1, wdata/be unchanged.
REQ-014 SHALL forward a failed SC as a load: out_wen_o=0, out_amo_o=AMONone; memory is not modified.
REQ-015 SHALL invalidate slot[in_id_i] on every SC handshake, whether it succeeds or fails.
REQ-016 SHALL, on any handshake writing memory (in_wen_i=1, any AMO except LR/SC, or successful SC), invalidate every valid slot whose address equals in_add_i, including the requester's own slot.
REQ-017 SHALL, in the cycle after an SC handshake, drive in_rdata_o with 32'd0 (success) or 32'd1 (failure) in the lane selected by in_be_i[4] at request time (upper if 1, DataWidth=64 only), all other bits zero.
REQ-018 SHALL pass out_rdata_i to in_rdata_o in every cycle not covered by REQ-017; response latency stays one cycle after handshake for all operations.
REQ-019 SHALL treat in_id_i >= NumCores as out of range: LR creates no reservation; SC fails.
REQ-020 SHALL not assign a reservation when an LR is requested but not granted; stalled requests (in_req_i=1, out_gnt_i=0) change nothing.
REQ-021 SHALL give a write-invalidate (REQ-016) and a same-cycle timeout expiry of the same slot the same result: slot invalid.

Reset
REQ-022 SHALL asynchronously clear all slot valid bits, addresses, SC response flags and (under REQ-031) counters on rst_ni low.
REQ-023 SHALL, during and after reset, present in_gnt_o=out_gnt_i and in_rdata_o=out_rdata_i; any SC response pending at reset is discarded.

Configuration
REQ-031 SHALL, with macro TCDM_LRSC_TIMEOUT_EN defined, give each slot a counter loaded with ResvTimeout on LR handshake, decremented every cycle while valid, and invalidate the slot when it reaches zero.
REQ-032 SHALL, without TCDM_LRSC_TIMEOUT_EN, contain no counters; reservations persist until REQ-015/REQ-016 clear them; ResvTimeout is ignored.

Structure
REQ-041 SHALL place amo_op_t (AMONone..AMOCAS plus AMOLR=4'hB, AMOSC=4'hC) in shared package tcdm_amo_pkg, used also by the downstream AMO stage.
REQ-042 SHALL instantiate NumCores copies of sub-module lrsc_resv_slot (valid, address, optional counter, set/clear/match logic).

Verification
REQ-051 LR id=2 addr 0x40, then SC id=2 addr 0x40 wdata 0xDEAD -> store forwarded, rdata lower lane 0 next cycle, memory 0xDEAD.
REQ-052 LR id=1 addr 0x40, store id=3 addr 0x40, SC id=1 addr 0x40 -> SC forwarded as load, rdata 1, memory unchanged.
REQ-053 LR id=0 addr 0x10, SC id=0 addr 0x14 -> fail rdata 1; repeat SC id=0 addr 0x10 -> fail (slot cleared).
REQ-054 SC id=4 be=8'hF0 with out_gnt_i low 3 cycles then high -> no state change while stalled; rdata[63:32]=1 one cycle after grant.
REQ-055 With TCDM_LRSC_TIMEOUT_EN, ResvTimeout=8: LR id=5 addr 0x80, SC after 10 cycles -> fail; SC after 4 cycles -> success.
REQ-056 LR id=6, assert rst_ni low one cycle, SC id=6 same address -> fail, rdata 1.

Source files
------------

// File: rtl/tcdm_amo_pkg.sv
// Shared atomic-operation encodings for the TCDM LR/SC filter and the downstream AMO stage.
package tcdm_amo_pkg;

  typedef enum logic [3:0] {
    AMONone = 4'h0,
    AMOSwap = 4'h1,
    AMOAdd  = 4'h2,
    AMOAnd  = 4'h3,
    AMOOr   = 4'h4,
    AMOXor  = 4'h5,
    AMOMax  = 4'h6,
    AMOMaxu = 4'h7,
    AMOMin  = 4'h8,
    AMOMinu = 4'h9,
    AMOCAS  = 4'hA,
    AMOLR   = 4'hB,
    AMOSC   = 4'hC
  } amo_op_t;

  localparam logic [31:0] ScSuccessCode = 32'd0;
  localparam logic [31:0] ScFailCode    = 32'd1;

  // Any operation other than LR/SC that carries a write enable or an AMO modifies memory.
  function automatic logic amoModifiesMem(input logic [3:0] amo, input logic wen);
    return (amo != AMOLR) && (amo != AMOSC) && (wen || (amo != AMONone));
  endfunction

endpackage

// File: rtl/lrsc_resv_slot.sv
// One reservation slot: valid bit, reserved address and, with TCDM_LRSC_TIMEOUT_EN defined,
// a lifetime counter that drops the reservation after ResvTimeout cycles.
module lrsc_resv_slot #(
  parameter int AddrMemWidth = 32,
  parameter int ResvTimeout  = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    i_set,
  input  logic                    i_clr,
  input  logic                    i_inv,
  input  logic [AddrMemWidth-1:0] i_addr,
  output logic                    o_valid,
  output logic                    o_match
);

  logic                    r_valid;
  logic [AddrMemWidth-1:0] r_addr;
  logic                    w_match;
  logic                    w_expire;

  assign w_match = r_valid && (r_addr == i_addr);
  assign o_valid = r_valid;
  assign o_match = w_match;

`ifdef TCDM_LRSC_TIMEOUT_EN
  localparam int CntWidth = (ResvTimeout > 1) ? $clog2(ResvTimeout + 1) : 1;

  logic [CntWidth-1:0] r_cnt;

  // Expiry coincides with the edge on which the counter would reach zero.
  assign w_expire = r_valid && (r_cnt == CntWidth'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (i_set) begin
      r_cnt <= CntWidth'(ResvTimeout);
    end else if (r_valid) begin
      r_cnt <= r_cnt - CntWidth'(1);
    end
  end
`else
  logic w_unusedTimeout;
  assign w_unusedTimeout = (ResvTimeout > 0);
  assign w_expire        = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
    end else if (i_set) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr;
    end else if (i_clr || (i_inv && w_match) || w_expire) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tcdm_lrsc_filter.sv
// LR/SC filter in front of the TCDM AMO stage: tracks one reservation per requester ID and
// turns LR/SC into plain loads/stores. Optional reservation timeout via TCDM_LRSC_TIMEOUT_EN.
module tcdm_lrsc_filter
  import tcdm_amo_pkg::*;
#(
  parameter int AddrMemWidth = 32,
  parameter int DataWidth    = 64,
  parameter int NumCores     = 8,
  parameter int ResvTimeout  = 1024,
  localparam int IdWidth     = (NumCores > 1) ? $clog2(NumCores) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_req_i,
  output logic                    in_gnt_o,
  input  logic [AddrMemWidth-1:0] in_add_i,
  input  logic [3:0]              in_amo_i,
  input  logic                    in_wen_i,
  input  logic [DataWidth-1:0]    in_wdata_i,
  input  logic [DataWidth/8-1:0]  in_be_i,
  input  logic [IdWidth-1:0]      in_id_i,
  output logic [DataWidth-1:0]    in_rdata_o,
  output logic                    out_req_o,
  input  logic                    out_gnt_i,
  output logic [AddrMemWidth-1:0] out_add_o,
  output logic [3:0]              out_amo_o,
  output logic                    out_wen_o,
  output logic [DataWidth-1:0]    out_wdata_o,
  output logic [DataWidth/8-1:0]  out_be_o,
  input  logic [DataWidth-1:0]    out_rdata_i
);

  logic                 w_hs;
  logic                 w_isLr;
  logic                 w_isSc;
  logic [31:0]          w_idExt;
  logic                 w_idInRange;
  logic                 w_ownMatch;
  logic                 w_scSuccess;
  logic                 w_memWrite;
  logic                 w_beUpper;
  logic [NumCores-1:0]  w_slotSet;
  logic [NumCores-1:0]  w_slotClr;
  logic [NumCores-1:0]  w_slotValid;
  logic [NumCores-1:0]  w_slotMatch;
  logic [DataWidth-1:0] w_scResp;

  logic r_scPending;
  logic r_scFail;
  logic r_scUpper;

  assign w_hs        = in_req_i && out_gnt_i;
  assign w_isLr      = (in_amo_i == AMOLR);
  assign w_isSc      = (in_amo_i == AMOSC);
  assign w_idExt     = 32'(in_id_i);
  assign w_idInRange = (w_idExt < 32'(NumCores));

  always_comb begin
    w_ownMatch = 1'b0;
    for (int k = 0; k < NumCores; k++) begin
      if (w_idExt == 32'(k)) begin
        w_ownMatch = w_slotMatch[k];
      end
    end
  end

  assign w_scSuccess = w_isSc && w_idInRange && w_ownMatch;
  assign w_memWrite  = w_scSuccess || amoModifiesMem(in_amo_i, in_wen_i);

  assign out_req_o   = in_req_i;
  assign in_gnt_o    = out_gnt_i;
  assign out_add_o   = in_add_i;
  assign out_wdata_o = in_wdata_i;
  assign out_be_o    = in_be_i;
  assign out_amo_o   = (w_isLr || w_isSc) ? 4'(AMONone) : in_amo_i;
  assign out_wen_o   = w_isLr ? 1'b0 : (w_isSc ? w_scSuccess : in_wen_i);

  // Address-match invalidation on writes also clears the requester's own slot.
  for (genvar k = 0; k < NumCores; k++) begin : g_slot
    assign w_slotSet[k] = w_hs && w_isLr && (w_idExt == 32'(k));
    assign w_slotClr[k] = w_hs && w_isSc && (w_idExt == 32'(k));

    lrsc_resv_slot #(
      .AddrMemWidth(AddrMemWidth),
      .ResvTimeout (ResvTimeout)
    ) u_slot (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .i_set  (w_slotSet[k]),
      .i_clr  (w_slotClr[k]),
      .i_inv  (w_hs && w_memWrite),
      .i_addr (in_add_i),
      .o_valid(w_slotValid[k]),
      .o_match(w_slotMatch[k])
    );
  end

  // DataWidth must be 32 or 64; the lane select only exists in the 64-bit build.
  if (DataWidth == 64) begin : g_resp64
    assign w_beUpper = in_be_i[4];
    assign w_scResp  = r_scUpper ? {31'd0, r_scFail, 32'd0} : {63'd0, r_scFail};
  end else begin : g_resp32
    logic w_unusedUpper;
    assign w_unusedUpper = r_scUpper;
    assign w_beUpper     = 1'b0;
    assign w_scResp      = {{(DataWidth-1){1'b0}}, r_scFail};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_scPending <= 1'b0;
      r_scFail    <= 1'b0;
      r_scUpper   <= 1'b0;
    end else begin
      r_scPending <= w_hs && w_isSc;
      if (w_hs && w_isSc) begin
        r_scFail  <= !w_scSuccess;
        r_scUpper <= w_beUpper;
      end
    end
  end

  assign in_rdata_o = r_scPending ? w_scResp : out_rdata_i;

endmodule
